// File: rtl/inert_seq.sv
// inert_seq: SPI read sequencer for the inertial sensor.
// After reset it waits PWR_WAIT cycles, writes four configuration registers,
// then on each data-ready interrupt reads eight bytes and publishes roll rate,
// yaw rate, AY and AZ together with a one-cycle vld pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   INT        sensor data-ready (asynchronous, double-flopped here)
//   spi_done   one-cycle pulse from the SPI master at end of a transaction
//   spi_rd     SPI receive word, only [7:0] used, valid with spi_done
//   spi_wrt    one-cycle pulse starting an SPI transaction
//   spi_cmd    command word for the SPI master, held until the next issue
//   init_done  sticky flag, configuration complete
//   vld        one-cycle pulse, new sample set on the four words below
//   roll_rt, yaw_rt, AY, AZ   signed sample words {high, low}
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_PWR      | power-up delay, counter runs up to PWR_WAIT and holds
// S_CFG_ISSUE| launch config write cfg[idx]
// S_CFG_BUSY | wait for spi_done of the config write
// S_IDLE     | configured, wait for synchronized INT
// S_RD_ISSUE | launch read rd[idx]
// S_RD_BUSY  | wait for spi_done, capture byte idx
// S_PUBLISH  | vld cycle, new words are visible

module inert_seq #(
   parameter logic [15:0] PWR_WAIT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        spi_done,
   input  logic [15:0] spi_rd,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   output logic        init_done,
   output logic        vld,
   output logic [15:0] roll_rt,
   output logic [15:0] yaw_rt,
   output logic [15:0] AY,
   output logic [15:0] AZ
);

   typedef enum logic [2:0] {
      S_PWR,
      S_CFG_ISSUE,
      S_CFG_BUSY,
      S_IDLE,
      S_RD_ISSUE,
      S_RD_BUSY,
      S_PUBLISH
   } state_t;

   state_t      state_q;
   logic [15:0] pwr_cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  hold_q [8];
   logic        int_meta_q;
   logic        int_sync_q;
   logic        spi_wrt_q;
   logic [15:0] spi_cmd_q;
   logic        init_done_q;
   logic        vld_q;
   logic [15:0] roll_q;
   logic [15:0] yaw_q;
   logic [15:0] ay_q;
   logic [15:0] az_q;

   logic [15:0] cfg_cmd_d;
   logic [15:0] rd_cmd_d;

   // The upper receive byte carries nothing for this sensor.
   logic unused_rd_hi;
   assign unused_rd_hi = ^spi_rd[15:8];

   always_comb begin
      cfg_cmd_d = 16'h0D02;
      case (idx_q[1:0])
         2'd0:    cfg_cmd_d = 16'h0D02;
         2'd1:    cfg_cmd_d = 16'h1053;
         2'd2:    cfg_cmd_d = 16'h1150;
         default: cfg_cmd_d = 16'h1460;
      endcase
   end

   always_comb begin
      rd_cmd_d = 16'hA400;
      case (idx_q)
         3'd0:    rd_cmd_d = 16'hA400;
         3'd1:    rd_cmd_d = 16'hA500;
         3'd2:    rd_cmd_d = 16'hA600;
         3'd3:    rd_cmd_d = 16'hA700;
         3'd4:    rd_cmd_d = 16'hAA00;
         3'd5:    rd_cmd_d = 16'hAB00;
         3'd6:    rd_cmd_d = 16'hAC00;
         default: rd_cmd_d = 16'hAD00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         int_meta_q <= 1'b0;
         int_sync_q <= 1'b0;
      end else begin
         int_meta_q <= INT;
         int_sync_q <= int_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_PWR;
         pwr_cnt_q   <= '0;
         idx_q       <= '0;
         for (int i = 0; i < 8; i++) hold_q[i] <= '0;
         spi_wrt_q   <= 1'b0;
         spi_cmd_q   <= '0;
         init_done_q <= 1'b0;
         vld_q       <= 1'b0;
         roll_q      <= '0;
         yaw_q       <= '0;
         ay_q        <= '0;
         az_q        <= '0;
      end else begin
         spi_wrt_q <= 1'b0;
         vld_q     <= 1'b0;
         case (state_q)
            S_PWR: begin
               // Counter parks at PWR_WAIT; only a reset clears it.
               if (pwr_cnt_q == PWR_WAIT) begin
                  idx_q   <= '0;
                  state_q <= S_CFG_ISSUE;
               end else begin
                  pwr_cnt_q <= pwr_cnt_q + 16'd1;
               end
            end
            S_CFG_ISSUE: begin
               spi_cmd_q <= cfg_cmd_d;
               spi_wrt_q <= 1'b1;
               state_q   <= S_CFG_BUSY;
            end
            S_CFG_BUSY: begin
               if (spi_done) begin
                  if (idx_q == 3'd3) begin
                     init_done_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     state_q <= S_CFG_ISSUE;
                  end
               end
            end
            S_IDLE: begin
               if (int_sync_q) begin
                  idx_q   <= '0;
                  state_q <= S_RD_ISSUE;
               end
            end
            S_RD_ISSUE: begin
               spi_cmd_q <= rd_cmd_d;
               spi_wrt_q <= 1'b1;
               state_q   <= S_RD_BUSY;
            end
            S_RD_BUSY: begin
               if (spi_done) begin
                  hold_q[idx_q] <= spi_rd[7:0];
                  if (idx_q == 3'd7) begin
                     // Words load on entry to PUBLISH so they appear together
                     // with vld, one cycle after the last byte arrives; the
                     // final high byte comes straight from the receive word.
                     roll_q  <= {hold_q[1], hold_q[0]};
                     yaw_q   <= {hold_q[3], hold_q[2]};
                     ay_q    <= {hold_q[5], hold_q[4]};
                     az_q    <= {spi_rd[7:0], hold_q[6]};
                     vld_q   <= 1'b1;
                     state_q <= S_PUBLISH;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     state_q <= S_RD_ISSUE;
                  end
               end
            end
            S_PUBLISH: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_PWR;
            end
         endcase
      end
   end

   assign spi_wrt   = spi_wrt_q;
   assign spi_cmd   = spi_cmd_q;
   assign init_done = init_done_q;
   assign vld       = vld_q;
   assign roll_rt   = roll_q;
   assign yaw_rt    = yaw_q;
   assign AY        = ay_q;
   assign AZ        = az_q;

endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: bench for inert_seq. A sensor model answers SPI commands from
// a register map; expected words come from the bytes returned per address.

module tb_inert_seq;

   localparam logic [15:0] PW = 16'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic        INT;
   logic        spi_done;
   logic [15:0] spi_rd;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        init_done;
   logic        vld;
   logic [15:0] roll_rt;
   logic [15:0] yaw_rt;
   logic [15:0] AY;
   logic [15:0] AZ;

   inert_seq #(.PWR_WAIT(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .INT       (INT),
      .spi_done  (spi_done),
      .spi_rd    (spi_rd),
      .spi_wrt   (spi_wrt),
      .spi_cmd   (spi_cmd),
      .init_done (init_done),
      .vld       (vld),
      .roll_rt   (roll_rt),
      .yaw_rt    (yaw_rt),
      .AY        (AY),
      .AZ        (AZ)
   );

   always #5 clk = ~clk;

   logic [15:0] cfg_tab [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
   logic [7:0]  rd_addr [8] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAA, 8'hAB, 8'hAC, 8'hAD};

   logic [7:0]  regmap [256];
   logic [7:0]  got [256];
   logic [15:0] cmd_log [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int since_rst = 0;
   int done_cnt = -1;
   int lat = 5;
   int cfg_dones = 0;
   int rd_dones = 0;
   int vld_count = 0;
   int wrt_count = 0;
   int vld_cyc = 0;
   int last_done_cyc = 0;
   int lat_probe = -1;
   bit stale = 0;
   bit force_done = 0;
   bit pub_pending = 0;
   bit init_pending = 0;
   bit exp_init = 0;
   bit wrt_prev = 0;
   logic [15:0] cur_cmd = '0;
   logic [15:0] m_roll = '0, m_yaw = '0, m_ay = '0, m_az = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit is_read(input logic [15:0] c);
      return (c[7:0] == 8'h00) &&
             (c[15:8] inside {8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAA, 8'hAB, 8'hAC, 8'hAD});
   endfunction

   task automatic deliver();
      if (stale) begin
         stale = 0;
      end else if (is_read(cur_cmd)) begin
         spi_rd[7:0] = regmap[cur_cmd[15:8]];
         got[cur_cmd[15:8]] = regmap[cur_cmd[15:8]];
         rd_dones++;
         if (rd_dones % 8 == 0) begin
            pub_pending = 1;
            last_done_cyc = cyc;
         end
      end else begin
         cfg_dones++;
         if (cfg_dones == 4) init_pending = 1;
      end
   endtask

   task automatic step();
      bit rst_was;
      bit exp_vld;
      rst_was = rst;
      @(posedge clk);
      #1;
      cyc++;
      since_rst++;
      exp_vld = pub_pending;
      pub_pending = 0;
      if (init_pending) begin
         exp_init = 1;
         init_pending = 0;
      end
      if (rst_was) begin
         since_rst = 0;
         exp_init = 0;
         exp_vld = 0;
         cfg_dones = 0;
         rd_dones = 0;
         m_roll = '0; m_yaw = '0; m_ay = '0; m_az = '0;
         if (done_cnt != -1) stale = 1;
      end
      if (exp_vld) begin
         m_roll = {got[8'hA5], got[8'hA4]};
         m_yaw  = {got[8'hA7], got[8'hA6]};
         m_ay   = {got[8'hAB], got[8'hAA]};
         m_az   = {got[8'hAD], got[8'hAC]};
      end
      check("vld", vld, exp_vld);
      check("init_done", init_done, exp_init);
      check("roll_rt", roll_rt, m_roll);
      check("yaw_rt", yaw_rt, m_yaw);
      check("AY", AY, m_ay);
      check("AZ", AZ, m_az);
      if (rst_was) begin
         check("rst_wrt", spi_wrt, 0);
         check("rst_cmd", spi_cmd, 0);
      end
      if (vld) begin
         vld_count++;
         vld_cyc = cyc;
      end
      // sensor side of the SPI link for the cycle now starting
      spi_done = 1'b0;
      spi_rd = 16'($urandom);
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) begin
            done_cnt = -1;
            spi_done = 1'b1;
            deliver();
         end
      end
      if (force_done) begin
         spi_done = 1'b1;
         force_done = 0;
      end
      if (spi_wrt) begin
         wrt_count++;
         cmd_log.push_back(spi_cmd);
         check("early_wrt", since_rst > int'(PW), 1);
         check("wrt_width", wrt_prev, 0);
         if (!stale) check("wrt_overlap", done_cnt == -1, 1);
         if (lat_probe >= 0) begin
            check("int_lat", cyc - lat_probe, 4);
            lat_probe = -1;
         end
         cur_cmd = spi_cmd;
         done_cnt = lat;
      end
      wrt_prev = spi_wrt;
   endtask

   task automatic wait_init(input int budget);
      int k;
      k = 0;
      while (!exp_init && k < budget) begin
         step();
         k++;
      end
      check("init_timeout", exp_init, 1);
   endtask

   task automatic wait_vld(input int n, input int budget);
      int k;
      k = 0;
      while (vld_count < n && k < budget) begin
         step();
         k++;
      end
      check("vld_timeout", vld_count >= n, 1);
   endtask

   task automatic check_cmds(input string tag, input int base, input int n, input bit rd);
      for (int i = 0; i < n; i++) begin
         logic [15:0] obs;
         logic [15:0] exp;
         obs = (base + i < cmd_log.size()) ? cmd_log[base + i] : 16'hDEAD;
         exp = rd ? {rd_addr[i % 8], 8'h00} : cfg_tab[i];
         check(tag, obs, exp);
      end
   endtask

   task automatic do_read(input int l, input int w, input bit probe);
      int base;
      int n0;
      lat = l;
      base = cmd_log.size();
      n0 = vld_count;
      INT = 1'b1;
      if (probe) lat_probe = cyc;
      repeat (w) step();
      INT = 1'b0;
      wait_vld(n0 + 1, 400);
      repeat (6) step();
      check("vld_count", vld_count - n0, 1);
      check("vld_lat", vld_cyc - last_done_cyc, 1);
      check_cmds("rd_cmd", base, 8, 1);
   endtask

   task automatic rand_regs();
      for (int i = 0; i < 8; i++) regmap[rd_addr[i]] = 8'($urandom);
   endtask

   initial begin
      int base;
      int n0;
      int w0;
      int r0;
      int k;
      for (int i = 0; i < 256; i++) regmap[i] = 8'($urandom);
      INT = 1'b0;
      spi_done = 1'b0;
      spi_rd = '0;
      rst = 1'b1;
      lat = 5;
      repeat (3) step();
      rst = 1'b0;

      // power-up and configuration
      wait_init(300);
      check("init_high", init_done, 1);
      check_cmds("cfg_cmd", 0, 4, 0);
      repeat (5) step();

      // fixed-byte assembly with INT-to-wrt latency probe
      for (int i = 0; i < 8; i++) regmap[rd_addr[i]] = 8'((i + 1) * 8'h11);
      do_read(5, 3, 1);
      check("asm_roll", roll_rt, 16'h2211);
      check("asm_yaw", yaw_rt, 16'h4433);
      check("asm_ay", AY, 16'h6655);
      check("asm_az", AZ, 16'h8877);

      // randomized reads
      for (int r = 0; r < 6; r++) begin
         rand_regs();
         do_read(int'($urandom_range(2, 9)), int'($urandom_range(1, 5)), 0);
      end

      // back-to-back with INT held high
      rand_regs();
      lat = 3;
      base = cmd_log.size();
      n0 = vld_count;
      INT = 1'b1;
      wait_vld(n0 + 2, 600);
      INT = 1'b0;
      repeat (120) step();
      check("b2b_vld", vld_count - n0 >= 2, 1);
      check("b2b_idle", rd_dones % 8, 0);
      check_cmds("b2b_cmd", base, 16, 1);

      // spurious done while idle
      w0 = wrt_count;
      n0 = vld_count;
      force_done = 1;
      repeat (6) step();
      check("spur_idle_wrt", wrt_count - w0, 0);
      check("spur_idle_vld", vld_count - n0, 0);

      // reset after the third done of a read
      rand_regs();
      lat = int'($urandom_range(2, 6));
      r0 = rd_dones;
      INT = 1'b1;
      step();
      INT = 1'b0;
      k = 0;
      while (rd_dones < r0 + 3 && k < 300) begin
         step();
         k++;
      end
      check("rst_wait", rd_dones >= r0 + 3, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_init", init_done, 0);
      check("rst_roll", roll_rt, 0);
      check("rst_az", AZ, 0);
      base = cmd_log.size();
      n0 = vld_count;
      step();
      force_done = 1;
      step();
      lat = 5;
      wait_init(300);
      check("rst_no_vld", vld_count - n0, 0);
      check_cmds("cfg_again", base, 4, 0);
      repeat (5) step();

      // sign extension of a negative full-scale sample
      rand_regs();
      regmap[8'hAC] = 8'h00;
      regmap[8'hAD] = 8'h80;
      do_read(4, 2, 0);
      check("az_sign", AZ, 16'h8000);
      check("az_signed", $signed(AZ) == -32768, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inert_seq.md
# inert_seq

Sequencer for the inertial sensor's SPI reads, feeding the inertial integrator. After reset it waits for sensor power-up and writes four configuration registers. It then waits for the sensor's data-ready interrupt, reads eight bytes over a shared SPI master, and assembles roll rate, yaw rate, AY and AZ. All four words are presented together with a single-cycle `vld` pulse.

## Interface
- `PWR_WAIT`, default 16'hFFFF: cycles to wait after reset before the first config write.
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `INT`  in  1  sensor data-ready, asynchronous.
- `spi_done`  in  1  one-cycle pulse from the SPI master when a transaction finishes.
- `spi_rd`  in  16  SPI receive word; only `[7:0]` is used. Valid in the `spi_done` cycle.
- `spi_wrt`  out  1  one-cycle pulse that starts an SPI transaction.
- `spi_cmd`  out  16  command word for the SPI master.
- `init_done`  out  1  high once configuration is complete; sticky until reset.
- `vld`  out  1  one-cycle pulse when a new sample set is valid.
- `roll_rt`, `yaw_rt`, `AY`, `AZ`  out  16 each  signed sample words.

## Operation
- `INT` is double-flopped before use. No other input is synchronized.
- Config commands, issued in order: 16'h0D02, 16'h1053, 16'h1150, 16'h1460.
- Read commands, issued in order: A4, A5, A6, A7, AA, AB, AC, AD in `spi_cmd[15:8]`, with `spi_cmd[7:0]` = 0. Byte mapping:
  - A4 = roll low, A5 = roll high
  - A6 = yaw low, A7 = yaw high
  - AA = AY low, AB = AY high
  - AC = AZ low, AD = AZ high
- The state machine uses a 3-bit command index `idx`:
  - PWR: a 16-bit counter counts up. When it reaches `PWR_WAIT`, go to CFG_ISSUE with `idx` = 0.
  - CFG_ISSUE: drive `spi_cmd` = cfg[`idx`] and pulse `spi_wrt`, then go to CFG_BUSY.
  - CFG_BUSY: on `spi_done`:
    - if `idx` = 3, set `init_done` and go to IDLE;
    - otherwise increment `idx` and go to CFG_ISSUE.
  - IDLE: when synchronized `INT` = 1, clear `idx` and go to RD_ISSUE.
  - RD_ISSUE: drive `spi_cmd` = rd[`idx`] and pulse `spi_wrt`, then go to RD_BUSY.
  - RD_BUSY: on `spi_done`, write `spi_rd[7:0]` into holding byte `idx`. Then:
    - if `idx` = 7, go to PUBLISH;
    - otherwise increment `idx` and go to RD_ISSUE.
  - PUBLISH: copy the holding bytes into the four output words as {high, low}, pulse `vld`, go to IDLE.
- Outputs change only in PUBLISH, so a partial set is never visible.
- `spi_cmd` holds its value from the issue cycle until the next issue. It is don't-care in PWR.

## Timing
- Reset values:
  - all outputs 0, including `spi_cmd` and all sample words;
  - state = PWR, power-up counter = 0, `idx` = 0, holding bytes = 0.
- `spi_wrt` is high for exactly one cycle per transaction. It never rises again before that transaction's `spi_done`.
- `spi_done` outside CFG_BUSY or RD_BUSY is ignored.
- `spi_done` in the same cycle as RD_ISSUE cannot occur and needs no handling.
- `vld` is asserted in the cycle after the eighth `spi_done` and lasts one cycle. The new sample words are visible in that same cycle.
- `INT` is level-sensitive and sampled only in IDLE:
  - if `INT` is still high when returning from PUBLISH, a new read sequence starts after one IDLE cycle;
  - `INT` pulses that occur entirely during a read sequence are lost.
- Minimum latency from the raw `INT` rising edge to `spi_wrt` is 4 cycles: 2 synchronizer flops, the IDLE decision, then RD_ISSUE.
- `init_done` rises in the cycle after the fourth config `spi_done`.
- Reset asserted mid-sequence:
  - next cycle all outputs are 0 and the block is back in PWR, with power-up delay restarted;
  - the SPI master is not aborted, and its late `spi_done` falls in PWR and is ignored.
- The power-up counter does not wrap. It stops once it reaches `PWR_WAIT`.

## Test plan
- Init (`PWR_WAIT` = 8, SPI model returns `done` 5 cycles after `wrt`):
  - expect four `spi_wrt` pulses with `spi_cmd` = 0D02, 1053, 1150, 1460;
  - `init_done` goes high after the fourth `done`;
  - no `spi_wrt` occurs during the first 8 cycles.
- Read assembly (after init, model returns bytes 11,22,33,44,55,66,77,88 in order; raise `INT`):
  - expect `roll_rt` = 16'h2211, `yaw_rt` = 16'h4433, `AY` = 16'h6655, `AZ` = 16'h8877;
  - exactly one `vld` pulse;
  - outputs unchanged before `vld`.
- Back-to-back (`INT` held high):
  - two complete read sequences with two `vld` pulses;
  - each sequence is 8 transactions in A4..AD order.
- Spurious `done` (pulse `spi_done` in IDLE and in PWR):
  - no state change, no capture, no `vld`.
- Reset mid-read (assert `rst` after the 3rd `done` of a read):
  - outputs 0 the next cycle, `init_done` = 0;
  - after reset release the full power-up and config sequence repeats.
- Sign check (AZ bytes 00, 80):
  - `AZ` = 16'h8000, read as signed -32768.
